// File: rtl/pcs_receive.sv
// 1000BASE-X PCS receive: decodes SUDI code-groups and runs the receive state machine
// that produces registered rxd / rx_dv / rx_er one cycle after each sampled code-group.
module pcs_receive #(
    parameter int CG_WIDTH    = 10,
    parameter int OCTET_WIDTH = 8
) (
    input  logic                   rx_clk,
    input  logic                   mr_main_reset,
    input  logic [CG_WIDTH:0]      sudi,
    input  logic                   sync_status,
    output logic [OCTET_WIDTH-1:0] rxd,
    output logic                   rx_dv,
    output logic                   rx_er
);

    typedef enum logic [2:0] {
        LINK_FAILED = 3'd0,
        WAIT_FOR_K  = 3'd1,
        RX_K        = 3'd2,
        IDLE_D      = 3'd3,
        RECEIVE     = 3'd4,
        TRI_RRI     = 3'd5,
        RX_ERR      = 3'd6
    } state_t;

    localparam logic [OCTET_WIDTH-1:0] OCTET_ZERO = {OCTET_WIDTH{1'b0}};
    localparam logic [OCTET_WIDTH-1:0] OCTET_SSD  = 8'h55;

    // 5b/6b decode over both disparity columns: {valid, EDCBA}
    function automatic logic [5:0] dec_5b6b(input logic [5:0] abcdei);
        logic [5:0] r;
        case (abcdei)
            6'b100111, 6'b011000: r = {1'b1, 5'd0};
            6'b011101, 6'b100010: r = {1'b1, 5'd1};
            6'b101101, 6'b010010: r = {1'b1, 5'd2};
            6'b110001:            r = {1'b1, 5'd3};
            6'b110101, 6'b001010: r = {1'b1, 5'd4};
            6'b101001:            r = {1'b1, 5'd5};
            6'b011001:            r = {1'b1, 5'd6};
            6'b111000, 6'b000111: r = {1'b1, 5'd7};
            6'b111001, 6'b000110: r = {1'b1, 5'd8};
            6'b100101:            r = {1'b1, 5'd9};
            6'b010101:            r = {1'b1, 5'd10};
            6'b110100:            r = {1'b1, 5'd11};
            6'b001101:            r = {1'b1, 5'd12};
            6'b101100:            r = {1'b1, 5'd13};
            6'b011100:            r = {1'b1, 5'd14};
            6'b010111, 6'b101000: r = {1'b1, 5'd15};
            6'b011011, 6'b100100: r = {1'b1, 5'd16};
            6'b100011:            r = {1'b1, 5'd17};
            6'b010011:            r = {1'b1, 5'd18};
            6'b110010:            r = {1'b1, 5'd19};
            6'b001011:            r = {1'b1, 5'd20};
            6'b101010:            r = {1'b1, 5'd21};
            6'b011010:            r = {1'b1, 5'd22};
            6'b111010, 6'b000101: r = {1'b1, 5'd23};
            6'b110011, 6'b001100: r = {1'b1, 5'd24};
            6'b100110:            r = {1'b1, 5'd25};
            6'b010110:            r = {1'b1, 5'd26};
            6'b110110, 6'b001001: r = {1'b1, 5'd27};
            6'b001110:            r = {1'b1, 5'd28};
            6'b101110, 6'b010001: r = {1'b1, 5'd29};
            6'b011110, 6'b100001: r = {1'b1, 5'd30};
            6'b101011, 6'b010100: r = {1'b1, 5'd31};
            default:              r = {1'b0, 5'd0};
        endcase
        return r;
    endfunction

    // 3b/4b decode for y = 0..6: {valid, HGF}; the y = 7 forms depend on x and are handled below
    function automatic logic [3:0] dec_3b4b(input logic [3:0] fghj);
        logic [3:0] r;
        case (fghj)
            4'b1011, 4'b0100: r = {1'b1, 3'd0};
            4'b1001:          r = {1'b1, 3'd1};
            4'b0101:          r = {1'b1, 3'd2};
            4'b1100, 4'b0011: r = {1'b1, 3'd3};
            4'b1101, 4'b0010: r = {1'b1, 3'd4};
            4'b1010:          r = {1'b1, 3'd5};
            4'b0110:          r = {1'b1, 3'd6};
            default:          r = {1'b0, 3'd0};
        endcase
        return r;
    endfunction

    logic [5:0]             d6_s;
    logic [3:0]             d4_s;
    logic                   x_a7m_s;
    logic                   x_a7p_s;
    logic                   y7_ok_s;
    logic                   is_data_s;
    logic                   is_k28_5_s;
    logic                   is_s_s;
    logic                   is_t_s;
    logic                   is_r_s;
    logic                   rx_even_s;
    logic [OCTET_WIDTH-1:0] octet_s;
    state_t                 state_r;

    // Classify the current code-group; D.x.A7 is only legal for x = 17/18/20 (0111) and 11/13/14 (1000)
    always_comb begin
        d6_s       = dec_5b6b(sudi[9:4]);
        d4_s       = dec_3b4b(sudi[3:0]);
        x_a7m_s    = (d6_s[4:0] == 5'd17) || (d6_s[4:0] == 5'd18) || (d6_s[4:0] == 5'd20);
        x_a7p_s    = (d6_s[4:0] == 5'd11) || (d6_s[4:0] == 5'd13) || (d6_s[4:0] == 5'd14);
        case (sudi[3:0])
            4'b1110: y7_ok_s = !x_a7m_s;
            4'b0001: y7_ok_s = !x_a7p_s;
            4'b0111: y7_ok_s = x_a7m_s;
            4'b1000: y7_ok_s = x_a7p_s;
            default: y7_ok_s = 1'b0;
        endcase
        is_data_s  = d6_s[5] && (d4_s[3] || y7_ok_s);
        if (d4_s[3]) begin
            octet_s = {d4_s[2:0], d6_s[4:0]};
        end else begin
            octet_s = {3'd7, d6_s[4:0]};
        end
        is_k28_5_s = (sudi[9:0] == 10'b0011111010) || (sudi[9:0] == 10'b1100000101);
        is_s_s     = (sudi[9:0] == 10'b1101101000) || (sudi[9:0] == 10'b0010010111);
        is_t_s     = (sudi[9:0] == 10'b1011101000) || (sudi[9:0] == 10'b0100010111);
        is_r_s     = (sudi[9:0] == 10'b1110101000) || (sudi[9:0] == 10'b0001010111);
        rx_even_s  = sudi[CG_WIDTH];
    end

    // Receive state machine with registered GMII-side outputs
    always_ff @(posedge rx_clk or negedge mr_main_reset) begin
        if (!mr_main_reset) begin
            state_r <= LINK_FAILED;
            rxd     <= OCTET_ZERO;
            rx_dv   <= 1'b0;
            rx_er   <= 1'b0;
        end else if (!sync_status) begin
            // Losing sync mid-frame must still mark the truncated frame as errored
            state_r <= LINK_FAILED;
            rxd     <= OCTET_ZERO;
            rx_dv   <= 1'b0;
            rx_er   <= (state_r == RECEIVE);
        end else begin
            rxd   <= OCTET_ZERO;
            rx_dv <= 1'b0;
            rx_er <= 1'b0;
            case (state_r)
                LINK_FAILED: state_r <= WAIT_FOR_K;
                WAIT_FOR_K: begin
                    if (is_k28_5_s && rx_even_s) state_r <= RX_K;
                    else                         state_r <= WAIT_FOR_K;
                end
                RX_K: begin
                    if (is_data_s) state_r <= IDLE_D;
                    else           state_r <= WAIT_FOR_K;
                end
                IDLE_D: begin
                    if (is_k28_5_s && rx_even_s) begin
                        state_r <= RX_K;
                    end else if (is_s_s && rx_even_s) begin
                        state_r <= RECEIVE;
                        rxd     <= OCTET_SSD;
                        rx_dv   <= 1'b1;
                    end else begin
                        state_r <= WAIT_FOR_K;
                    end
                end
                RECEIVE: begin
                    if (is_data_s) begin
                        state_r <= RECEIVE;
                        rxd     <= octet_s;
                        rx_dv   <= 1'b1;
                    end else if (is_t_s) begin
                        state_r <= TRI_RRI;
                    end else begin
                        state_r <= RX_ERR;
                        rx_dv   <= 1'b1;
                        rx_er   <= 1'b1;
                    end
                end
                RX_ERR: begin
                    if (is_k28_5_s && rx_even_s) begin
                        state_r <= RX_K;
                    end else begin
                        state_r <= RX_ERR;
                        rx_dv   <= 1'b1;
                        rx_er   <= 1'b1;
                    end
                end
                TRI_RRI: begin
                    if (is_r_s)                       state_r <= TRI_RRI;
                    else if (is_k28_5_s && rx_even_s) state_r <= RX_K;
                    else                              state_r <= WAIT_FOR_K;
                end
                default: state_r <= LINK_FAILED;
            endcase
        end
    end

endmodule

// File: tb/tb_pcs_receive.sv
// Directed bench for pcs_receive: each code-group is applied, then {rx_dv, rx_er, rxd}
// is compared against a hand-derived value one cycle later.
module tb_pcs_receive;

    logic        rx_clk;
    logic        mr_main_reset;
    logic [10:0] sudi;
    logic        sync_status;
    logic [7:0]  rxd;
    logic        rx_dv;
    logic        rx_er;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [9:0] K28_5N = 10'b0011111010;
    localparam logic [9:0] K28_5P = 10'b1100000101;
    localparam logic [9:0] CG_S   = 10'b1101101000;
    localparam logic [9:0] CG_T   = 10'b1011101000;
    localparam logic [9:0] CG_R   = 10'b1110101000;
    localparam logic [9:0] CG_V   = 10'b0111101000;
    localparam logic [9:0] D16_2  = 10'b0110110101;
    localparam logic [9:0] D21_2  = 10'b1010100101;
    localparam logic [9:0] D21_6  = 10'b1010100110;
    localparam logic [9:0] D1_0   = 10'b0111010100;
    localparam logic [9:0] D11_5  = 10'b1101001010;
    localparam logic [9:0] D17_7  = 10'b1000110111;
    localparam logic [9:0] D11_7  = 10'b1101001000;
    localparam logic [9:0] D0_7   = 10'b1001110001;
    localparam logic [9:0] CG_BAD = 10'b0000000000;

    localparam logic [9:0] QUIET = 10'h000;
    localparam logic [9:0] ERRV  = {2'b11, 8'h00};
    localparam logic [9:0] EOE   = {2'b01, 8'h00};

    pcs_receive #(.CG_WIDTH(10), .OCTET_WIDTH(8)) dut (
        .rx_clk        (rx_clk),
        .mr_main_reset (mr_main_reset),
        .sudi          (sudi),
        .sync_status   (sync_status),
        .rxd           (rxd),
        .rx_dv         (rx_dv),
        .rx_er         (rx_er)
    );

    initial begin
        rx_clk = 1'b0;
        forever #5 rx_clk = ~rx_clk;
    end

    task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got dv/er/rxd=%h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] data(input logic [7:0] o);
        return {2'b10, o};
    endfunction

    task automatic step_chk(input string tag, input logic [9:0] cg, input logic even,
                            input logic [9:0] exp);
        sudi = {even, cg};
        @(posedge rx_clk);
        #1;
        check_val(tag, {rx_dv, rx_er, rxd}, exp);
    endtask

    task automatic idle(input int pairs);
        for (int i = 0; i < pairs; i++) begin
            step_chk("idle_k", K28_5N, 1'b1, QUIET);
            step_chk("idle_d", D16_2, 1'b0, QUIET);
        end
    endtask

    initial begin
        mr_main_reset = 1'b0;
        sync_status   = 1'b1;
        sudi          = 11'h000;
        #3;
        check_val("reset_state", {rx_dv, rx_er, rxd}, QUIET);
        #4;
        mr_main_reset = 1'b1;

        // Idle pattern only: outputs stay quiet, ends in IDLE_D
        idle(3);

        // Normal frame with preamble, SFD, payload, termination
        step_chk("ssd", CG_S, 1'b1, data(8'h55));
        for (int i = 0; i < 6; i++) step_chk("pre", D21_2, i[0], data(8'h55));
        step_chk("sfd", D21_6, 1'b0, data(8'hD5));
        step_chk("d01", D1_0, 1'b1, data(8'h01));
        step_chk("dab", D11_5, 1'b0, data(8'hAB));
        step_chk("term", CG_T, 1'b1, QUIET);
        step_chk("rr", CG_R, 1'b0, QUIET);
        step_chk("rr2", CG_R, 1'b1, QUIET);
        step_chk("k_after_r", K28_5N, 1'b1, QUIET);
        step_chk("d_after_r", D16_2, 1'b0, QUIET);

        // Alternate-7 data forms, then invalid group holds error until EVEN K28.5
        step_chk("ssd2", CG_S, 1'b1, data(8'h55));
        step_chk("d17_7", D17_7, 1'b0, data(8'hF1));
        step_chk("d11_7", D11_7, 1'b1, data(8'hEB));
        step_chk("d0_7", D0_7, 1'b0, data(8'hE0));
        step_chk("invalid", CG_BAD, 1'b1, ERRV);
        step_chk("err_hold_d", D21_2, 1'b0, ERRV);
        step_chk("err_k_odd", K28_5N, 1'b0, ERRV);
        step_chk("err_k_even", K28_5N, 1'b1, QUIET);
        step_chk("err_idle_d", D16_2, 1'b0, QUIET);

        // /S/ on ODD in IDLE_D is ignored and drops back to WAIT_FOR_K
        step_chk("s_odd", CG_S, 1'b0, QUIET);
        step_chk("wait_s_even", CG_S, 1'b1, QUIET);
        idle(1);

        // /V/ mid-frame, recovery through K28.5 of the other disparity
        step_chk("ssd3", CG_S, 1'b1, data(8'h55));
        step_chk("v_err", CG_V, 1'b0, ERRV);
        step_chk("k_plus_even", K28_5P, 1'b1, QUIET);
        step_chk("idle_d3", D16_2, 1'b0, QUIET);

        // Sync loss mid-frame: one-cycle rx_er then quiet until a fresh idle pair
        step_chk("ssd4", CG_S, 1'b1, data(8'h55));
        step_chk("d01_b", D1_0, 1'b0, data(8'h01));
        sync_status = 1'b0;
        step_chk("sync_drop", D11_5, 1'b1, EOE);
        step_chk("sync_low", D11_5, 1'b0, QUIET);
        sync_status = 1'b1;
        step_chk("sync_back_s", CG_S, 1'b1, QUIET);
        step_chk("wait_s", CG_S, 1'b1, QUIET);
        idle(1);
        sync_status = 1'b0;
        step_chk("sync_prio", CG_S, 1'b1, QUIET);
        sync_status = 1'b1;
        step_chk("lf_exit", D16_2, 1'b0, QUIET);
        idle(1);

        // Asynchronous reset between edges mid-frame
        step_chk("ssd5", CG_S, 1'b1, data(8'h55));
        step_chk("dab_b", D11_5, 1'b0, data(8'hAB));
        #2;
        mr_main_reset = 1'b0;
        #1;
        check_val("async_reset", {rx_dv, rx_er, rxd}, QUIET);
        #1;
        mr_main_reset = 1'b1;
        step_chk("rst_s1", CG_S, 1'b1, QUIET);
        step_chk("rst_s2", CG_S, 1'b1, QUIET);
        step_chk("rst_d", D21_2, 1'b0, QUIET);
        idle(2);
        step_chk("ssd6", CG_S, 1'b1, data(8'h55));
        step_chk("term6", CG_T, 1'b0, QUIET);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
